serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised bit-serial adder/subtractor. It computes one result bit per clock using the team's full-adder equations: S = a^b^c and C = ab + ac + bc. Operand width is set by a parameter, and the block adds a subtract mode, signed-overflow detection and a start/done handshake. It sits beside the combinational adders in the game datapath, where area matters more than latency (score and line-count arithmetic).

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = a+b, 1 = a−b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while state = RUN.
- done  out  1  one-cycle pulse when the result is updated.
- sum  out  WIDTH  result, low WIDTH bits.
- cout  out  1  carry out of the MSB. In subtract mode this is the no-borrow flag (1 iff a ≥ b, unsigned).
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when start=1.
  - Latch ra=a and rb = sub ? ~b : b.
  - Set carry c = sub, bit counter n = 0, clear the shift register.
- RUN, every clock:
  - Bit0 = ra[0]^rb[0]^c.
  - c ← ra[0]&rb[0] | ra[0]&c | rb[0]&c.
  - Shift bit0 into the MSB of the result shift register.
  - Shift ra and rb right by one; n ← n+1.
  - When n = WIDTH−2, capture c as cmsb (the carry into the MSB).
  - On the clock that processes bit WIDTH−1:
    - Load sum from the full shift register.
    - Set cout ← final carry and ovf ← cmsb ^ final carry.
    - Go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1 here: begin a new operation exactly as from IDLE (back-to-back).
  - Otherwise go to IDLE.
- start in RUN is ignored. Operands, sub and the operation in flight are unaffected.
- sum, cout and ovf change only at completion. They hold their value until the next completion or reset.
- a, b and sub may change freely after the start cycle without affecting the result.
- Arithmetic is modulo 2^WIDTH. No saturation.
- rst (any state, including mid-RUN) takes effect immediately:
  - State = IDLE; busy = done = 0.
  - sum = 0, cout = 0, ovf = 0.
  - Internal registers and counter are cleared; the operation in flight is discarded.
  - After rst deasserts, the first start is accepted on the first rising edge.

## Timing
- Reset values: busy 0, done 0, sum 0, cout 0, ovf 0, state IDLE.
- Latency: start sampled at edge k → busy high from edge k through edge k+WIDTH.
- At edge k+WIDTH: results valid and done=1 for the cycle following that edge.
- Throughput: one result per WIDTH+1 cycles with back-to-back starts held high.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH−1 and resets to 0 on each accepted start.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, add:
  - a=100, b=27, start pulse → busy for 8 cycles, then done pulse with sum=127, cout=0, ovf=0.
  - a=200, b=100 → sum=44, cout=1, ovf=0.
  - a=127, b=1 → sum=128, ovf=1, cout=0.
- WIDTH=8, subtract:
  - sub=1, a=5, b=7 → sum=254, cout=0, ovf=0.
  - a=7, b=5 → sum=2, cout=1.
  - a=128, b=1 → sum=127, ovf=1.
- Handshake:
  - Pulse start again and toggle a, b, sub during RUN → no effect; the first result is reported exactly 8 edges after the accepted start.
  - Hold start=1 continuously → done every 9 cycles, and each result matches the operands sampled in IDLE/DONE.
- Reset mid-operation:
  - Assert rst asynchronously 4 cycles into RUN → busy, done, sum, cout and ovf drop to 0 immediately.
  - After release, a new start with a=3, b=4 → sum=7 after 8 cycles, with no residue from the aborted operation.
- Parameter sweep, WIDTH=2 and WIDTH=32:
  - Exhaustive test at WIDTH=2 in both modes.
  - 32-bit: a=0xFFFFFFFF, b=1 → sum=0, cout=1, ovf=0.
  - Latency equals WIDTH edges from the accepted start to done.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Results (sum, cout, ovf) are loaded only on completion and held until the next one.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-2:0] r_sr;
  logic [CW-1:0]    r_n;
  logic             r_c;
  logic             r_cmsb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_bit;
  logic             w_carry;
  logic [WIDTH-1:0] w_shift;

  assign w_bit   = r_ra[0] ^ r_rb[0] ^ r_c;
  assign w_carry = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_c) | (r_rb[0] & r_c);
  assign w_shift = {w_bit, r_sr};
  assign w_last  = (r_n == CW'(WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        // A start seen in the done cycle chains straight into the next operation.
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_sr   <= '0;
      r_n    <= '0;
      r_c    <= 1'b0;
      r_cmsb <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_busy <= (w_state_next == RUN);
      r_done <= (w_state_next == DONE);
      if (w_accept) begin
        // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
        r_ra   <= a;
        r_rb   <= sub ? ~b : b;
        r_c    <= sub;
        r_n    <= '0;
        r_sr   <= '0;
        r_cmsb <= 1'b0;
      end else if (r_state == RUN) begin
        r_c  <= w_carry;
        r_sr <= w_shift[WIDTH-1:1];
        r_ra <= r_ra >> 1;
        r_rb <= r_rb >> 1;
        if (!w_last) r_n <= r_n + CW'(1);
        if (r_n == CW'(WIDTH - 2)) r_cmsb <= w_carry;
        if (w_last) begin
          r_sum  <= w_shift;
          r_cout <= w_carry;
          r_ovf  <= r_cmsb ^ w_carry;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 2, 8 and 32, checked each cycle against an
// arithmetic reference model, plus literal expectations for the known cases.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  st = '0;
  logic        sub_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [2:0]  busy_v, done_v, cout_v, ovf_v;
  logic [1:0]  sum2;
  logic [7:0]  sum8;
  logic [31:0] sum32;
  bit          cmp_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sub_i), .a(a_i[1:0]), .b(b_i[1:0]),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum2), .cout(cout_v[0]), .ovf(ovf_v[0]));
  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sub_i), .a(a_i[7:0]), .b(b_i[7:0]),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum8), .cout(cout_v[1]), .ovf(ovf_v[1]));
  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sub_i), .a(a_i), .b(b_i),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum32), .cout(cout_v[2]), .ovf(ovf_v[2]));

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  function automatic int wof(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 8 : 32);
  endfunction

  function automatic logic [31:0] sum_of(input int i);
    return (i == 0) ? {30'b0, sum2} : ((i == 1) ? {24'b0, sum8} : sum32);
  endfunction

  // Reference result from plain integer arithmetic on unsigned and signed views.
  function automatic res_t predict(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic sb);
    longint m   = (longint'(1) << w) - 1;
    longint ua  = longint'(av) & m;
    longint ub  = longint'(bv) & m;
    longint sa  = (ua > (m >> 1)) ? ua - (m + 1) : ua;
    longint sbv = (ub > (m >> 1)) ? ub - (m + 1) : ub;
    longint t   = sb ? ua - ub : ua + ub;
    longint r   = sb ? sa - sbv : sa + sbv;
    res_t   res;
    res.s = 32'(t & m);
    res.c = sb ? (ua >= ub) : (t > m);
    res.o = (r > (m >> 1)) || (r < -((m + 1) >> 1));
    return res;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: remaining busy cycles per instance; a start is taken only when nothing is pending.
  int       rem[3] = '{0, 0, 0};
  logic [2:0] e_done = '0;
  res_t     e_res[3] = '{'0, '0, '0};
  res_t     p_res[3] = '{'0, '0, '0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        rem[i]    <= 0;
        e_done[i] <= 1'b0;
        e_res[i]  <= '0;
      end else if (rem[i] > 0) begin
        rem[i]    <= rem[i] - 1;
        e_done[i] <= (rem[i] == 1);
        if (rem[i] == 1) e_res[i] <= p_res[i];
      end else begin
        e_done[i] <= 1'b0;
        if (st[i]) begin
          rem[i]   <= wof(i);
          p_res[i] <= predict(wof(i), a_i, b_i, sub_i);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("w%0d.busy", wof(i)), 64'(busy_v[i]), 64'(rem[i] > 0));
        chk($sformatf("w%0d.done", wof(i)), 64'(done_v[i]), 64'(e_done[i]));
        chk($sformatf("w%0d.sum", wof(i)),  64'(sum_of(i)), 64'(e_res[i].s));
        chk($sformatf("w%0d.cout", wof(i)), 64'(cout_v[i]), 64'(e_res[i].c));
        chk($sformatf("w%0d.ovf", wof(i)),  64'(ovf_v[i]),  64'(e_res[i].o));
      end
    end
  end

  task automatic op(input int i, input logic [31:0] av, input logic [31:0] bv, input logic s,
                    input bit poke, output logic [31:0] rs, output logic rc, output logic ro);
    int lat;
    @(posedge clk); #2;
    a_i = av; b_i = bv; sub_i = s; st[i] = 1'b1;
    @(posedge clk); #2;
    st[i] = 1'b0; a_i = $urandom; b_i = $urandom; sub_i = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      st[i] = poke && (lat == 2);
    end while (!done_v[i] && lat < 70);
    st[i] = 1'b0;
    chk($sformatf("w%0d.latency", wof(i)), 64'(lat), 64'(wof(i)));
    rs = sum_of(i); rc = cout_v[i]; ro = ovf_v[i];
    $display("op w=%0d a=%0d b=%0d sub=%0d -> sum=%0d cout=%0d ovf=%0d lat=%0d",
             wof(i), av, bv, s, rs, rc, ro, lat);
  endtask

  task automatic lit(input int i, input logic [31:0] av, input logic [31:0] bv, input logic s,
                     input bit poke, input logic [31:0] es, input logic ec, input logic eo);
    logic [31:0] rs;
    logic        rc, ro;
    op(i, av, bv, s, poke, rs, rc, ro);
    chk($sformatf("lit.sum(%0d,%0d,%0d)", av, bv, s),  64'(rs), 64'(es));
    chk($sformatf("lit.cout(%0d,%0d,%0d)", av, bv, s), 64'(rc), 64'(ec));
    chk($sformatf("lit.ovf(%0d,%0d,%0d)", av, bv, s),  64'(ro), 64'(eo));
  endtask

  initial begin
    logic [31:0] rs;
    logic        rc, ro;
    int          last, nd;

    #1 rst = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("reset.busy", 64'(busy_v), 64'(0));
    chk("reset.done", 64'(done_v), 64'(0));
    chk("reset.sum8", 64'(sum8), 64'(0));
    chk("reset.flags", 64'({cout_v, ovf_v}), 64'(0));

    lit(1, 100, 27, 1'b0, 1'b0, 127, 1'b0, 1'b0);
    lit(1, 200, 100, 1'b0, 1'b0, 44, 1'b1, 1'b0);
    lit(1, 127, 1, 1'b0, 1'b0, 128, 1'b0, 1'b1);
    lit(1, 5, 7, 1'b1, 1'b0, 254, 1'b0, 1'b0);
    lit(1, 7, 5, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    lit(1, 128, 1, 1'b1, 1'b0, 127, 1'b1, 1'b1);

    // Abort an operation four cycles into RUN with an off-edge reset.
    @(posedge clk); #2;
    a_i = 50; b_i = 60; sub_i = 1'b0; st[1] = 1'b1;
    @(posedge clk); #2;
    st[1] = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst.busy", 64'(busy_v[1]), 64'(0));
    chk("midrst.done", 64'(done_v[1]), 64'(0));
    chk("midrst.sum",  64'(sum8), 64'(0));
    chk("midrst.cout", 64'(cout_v[1]), 64'(0));
    chk("midrst.ovf",  64'(ovf_v[1]), 64'(0));
    @(posedge clk); #2 rst = 1'b0;
    lit(1, 3, 4, 1'b0, 1'b0, 7, 1'b0, 1'b0);

    // A second start pulse during RUN must be ignored.
    lit(1, 20, 30, 1'b0, 1'b1, 50, 1'b0, 1'b0);

    // Start held high: one result every WIDTH+1 cycles.
    @(posedge clk); #2;
    st[1] = 1'b1; a_i = $urandom; b_i = $urandom; sub_i = 1'($urandom);
    last = -1; nd = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(posedge clk); #1;
      if (done_v[1]) begin
        if (last >= 0) chk("b2b.period", 64'(cyc - last), 64'(9));
        last = cyc;
        nd++;
      end
      #1;
      a_i = $urandom; b_i = $urandom; sub_i = 1'($urandom);
    end
    st[1] = 1'b0;
    chk("b2b.count", 64'(nd >= 4), 64'(1));
    repeat (12) @(posedge clk);

    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int s = 0; s < 2; s++)
          op(0, 32'(x), 32'(y), 1'(s), 1'b0, rs, rc, ro);

    lit(2, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    lit(2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

    // Random traffic on all three widths, with occasional off-edge resets.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #2;
      for (int i = 0; i < 3; i++) st[i] = ($urandom % 4 == 0);
      a_i = $urandom; b_i = $urandom; sub_i = 1'($urandom);
      if ($urandom % 250 == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    st = '0;
    repeat (40) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
